// File: rtl/fir_pkg.sv
// Shared types, defaults and the fixed coefficient ROM contents for the serial FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_LENGTH = 64;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int COEFF_COUNT    = 64;
    localparam int COEFF_W        = 16;

    // Linear ramp 1300 - 24*k in Q1.15; the taps sum to 34816, slightly above 1.0.
    localparam logic signed [COEFF_W-1:0] COEFFS [COEFF_COUNT] = '{
        16'sd1300, 16'sd1276, 16'sd1252, 16'sd1228, 16'sd1204, 16'sd1180, 16'sd1156, 16'sd1132,
        16'sd1108, 16'sd1084, 16'sd1060, 16'sd1036, 16'sd1012, 16'sd988,  16'sd964,  16'sd940,
        16'sd916,  16'sd892,  16'sd868,  16'sd844,  16'sd820,  16'sd796,  16'sd772,  16'sd748,
        16'sd724,  16'sd700,  16'sd676,  16'sd652,  16'sd628,  16'sd604,  16'sd580,  16'sd556,
        16'sd532,  16'sd508,  16'sd484,  16'sd460,  16'sd436,  16'sd412,  16'sd388,  16'sd364,
        16'sd340,  16'sd316,  16'sd292,  16'sd268,  16'sd244,  16'sd220,  16'sd196,  16'sd172,
        16'sd148,  16'sd124,  16'sd100,  16'sd76,   16'sd52,   16'sd28,   16'sd4,    -16'sd20,
        -16'sd44,  -16'sd68,  -16'sd92,  -16'sd116, -16'sd140, -16'sd164, -16'sd188, -16'sd212
    };

    function automatic int acc_width(input int length, input int width);
        return 2 * width + $clog2(length);
    endfunction

    function automatic logic signed [COEFF_W-1:0] coeff_q15(input int idx);
        return COEFFS[idx % COEFF_COUNT];
    endfunction

endpackage

// File: rtl/fir_shift_reg.sv
// Tap delay line: load shifts a new sample into tap 0, rotate circulates the line so
// every tap passes through tap 0 (the multiplier input) once per LENGTH rotations.
module fir_shift_reg
    import fir_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    rotate,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] head
);

    logic signed [WIDTH-1:0] taps [LENGTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                taps[i] <= '0;
            end
        end else if (load) begin
            taps[0] <= sample;
            for (int i = 1; i < LENGTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end else if (rotate) begin
            // Tap k moves toward tap 0, so tap 0 walks x[n], x[n-1], ... in order.
            for (int i = 0; i < LENGTH - 1; i++) begin
                taps[i] <= taps[i+1];
            end
            taps[LENGTH-1] <= taps[0];
        end
    end

    assign head = taps[0];

endmodule

// File: rtl/fir_filter.sv
// Serial FIR filter: one multiply-accumulate per clock over a rotating tap line.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping on overflow.
module fir_filter
    import fir_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] FIR_input,
    input  logic                    input_valid,
    output logic signed [WIDTH-1:0] FIR_output,
    output logic                    output_valid
);

    localparam int ACC_W  = acc_width(LENGTH, WIDTH);
    localparam int PROD_W = 2 * WIDTH;
    localparam int IDX_W  = $clog2(LENGTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH);

    state_t                   state;
    state_t                   state_next;
    logic                     accept;
    logic                     load;
    logic                     rotate;
    logic                     cnt_done;
    logic [CNT_W-1:0]         cnt;
    logic signed [WIDTH-1:0]  sample_p0;
    logic signed [WIDTH-1:0]  tap_head;
    logic signed [COEFF_W-1:0] coeff_raw;
    logic signed [WIDTH-1:0]  coeff;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  acc_p2;

    function automatic logic signed [WIDTH-1:0] to_output(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SATURATE_EN
        logic [ACC_W-2*WIDTH+1:0] top;
        top = a[ACC_W-1:2*WIDTH-2];
        if (top == '0 || top == '1) begin
            return a[2*WIDTH-2:WIDTH-1];
        end else if (a[ACC_W-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        return a[2*WIDTH-2:WIDTH-1];
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        rotate     = 1'b0;
        case (state)
            IDLE: begin
                if (input_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                // The extra CALC cycle drains the product pipeline without rotating.
                rotate = !cnt_done;
                if (cnt_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cnt_done = (state == CALC) && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (state == CALC && !cnt_done) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Stage p0: capture the sample on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_p0 <= '0;
        end else if (accept) begin
            sample_p0 <= FIR_input;
        end
    end

    fir_shift_reg #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH)
    ) u_taps (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .rotate (rotate),
        .sample (sample_p0),
        .head   (tap_head)
    );

    assign coeff_raw = coeff_q15(int'(cnt[IDX_W-1:0]));

    if (WIDTH == COEFF_W) begin : g_coeff_same
        assign coeff = coeff_raw;
    end else if (WIDTH > COEFF_W) begin : g_coeff_wide
        assign coeff = {coeff_raw, {(WIDTH-COEFF_W){1'b0}}};
    end else begin : g_coeff_narrow
        assign coeff = coeff_raw[COEFF_W-1 -: WIDTH];
    end

    // Stage p1/p2: registered product, then accumulate the previous product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_p1 <= '0;
            acc_p2  <= '0;
        end else if (load) begin
            prod_p1 <= '0;
            acc_p2  <= '0;
        end else if (state == CALC) begin
            prod_p1 <= tap_head * coeff;
            acc_p2  <= acc_p2 + ACC_W'(prod_p1);
        end
    end

    // Output stage: result holds until the next DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FIR_output   <= '0;
            output_valid <= 1'b0;
        end else begin
            output_valid <= (state == DONE);
            if (state == DONE) begin
                FIR_output <= to_output(acc_p2);
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter with the default 64-tap, 16-bit configuration.
module tb_fir_filter;

    localparam int LENGTH = 64;
    localparam int WIDTH  = 16;
    localparam int ACC_W  = 2 * WIDTH + 6;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    input_valid = 1'b0;
    logic signed [WIDTH-1:0] FIR_input = '0;
    logic signed [WIDTH-1:0] FIR_output;
    logic                    output_valid;

    int checks = 0;
    int errors = 0;

    fir_filter #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .FIR_input    (FIR_input),
        .input_valid  (input_valid),
        .FIR_output   (FIR_output),
        .output_valid (output_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // Presents one sample while the block is idle and waits for its result.
    task automatic send_sample(input logic signed [WIDTH-1:0] value,
                               output logic signed [WIDTH-1:0] result, output int lat);
        FIR_input   = value;
        input_valid = 1'b1;
        @(posedge clk); #1;
        input_valid = 1'b0;
        lat    = 0;
        result = 'x;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (output_valid) begin
                result = FIR_output;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            checks++;
            if (FIR_output !== 16'h0000 || output_valid !== 1'b0 || dut.state !== 2'd0) begin
                errors++;
                $display("FAIL reset[%0d]: out=%h vld=%b state=%0d required 0000/0/0",
                         i, FIR_output, output_valid, dut.state);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_impulse();
        logic signed [WIDTH-1:0] res;
        logic signed [WIDTH-1:0] exp;
        int lat;
        for (int k = 0; k < LENGTH; k++) begin
            send_sample((k == 0) ? 16'sh4000 : 16'sh0000, res, lat);
            exp = WIDTH'(650 - 12 * k);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL impulse[%0d]: got %h required %h", k, res, exp);
            end
            checks++;
            if (lat !== LENGTH + 3) begin
                errors++;
                $display("FAIL impulse_latency[%0d]: got %0d required %0d", k, lat, LENGTH + 3);
            end
        end
    endtask

    task automatic test_zero();
        logic signed [WIDTH-1:0] res;
        int lat;
        for (int k = 0; k < 3; k++) begin
            send_sample(16'sh0000, res, lat);
            checks++;
            if (res !== 16'h0000) begin
                errors++;
                $display("FAIL zero[%0d]: got %h required 0000", k, res);
            end
            checks++;
            if (lat !== LENGTH + 3) begin
                errors++;
                $display("FAIL zero_latency[%0d]: got %0d required %0d", k, lat, LENGTH + 3);
            end
            @(posedge clk); #1;
            checks++;
            if (output_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_pulse_width[%0d]: output_valid=%b required 0", k, output_valid);
            end
        end
    endtask

    task automatic test_rotation();
        logic signed [WIDTH-1:0] res;
        int lat;
        fork
            send_sample(16'sh1234, res, lat);
            begin
                logic signed [ACC_W-1:0]   prev_acc;
                logic signed [2*WIDTH-1:0] prev_prod;
                int cyc = 0;
                int calc_n = 0;
                bit prev_calc = 1'b0;
                bit seen_done = 1'b0;
                prev_acc  = '0;
                prev_prod = '0;
                while (cyc < 200 && !seen_done) begin
                    @(negedge clk);
                    cyc++;
                    if (prev_calc && (dut.state == 2'd2 || dut.state == 2'd3)) begin
                        checks++;
                        if (dut.acc_p2 !== prev_acc + ACC_W'(prev_prod)) begin
                            errors++;
                            $display("FAIL acc_step[%0d]: got %h required %h", calc_n,
                                     dut.acc_p2, prev_acc + ACC_W'(prev_prod));
                        end
                    end
                    if (dut.state == 2'd2) begin
                        if (calc_n == 0) begin
                            checks++;
                            if (dut.tap_head !== 16'sh1234) begin
                                errors++;
                                $display("FAIL tap0_load: got %h required 1234", dut.tap_head);
                            end
                        end
                        calc_n++;
                    end
                    if (dut.state == 2'd3) begin
                        seen_done = 1'b1;
                        checks++;
                        if (dut.tap_head !== 16'sh1234) begin
                            errors++;
                            $display("FAIL tap0_rotated: got %h required 1234", dut.tap_head);
                        end
                        checks++;
                        if (calc_n !== LENGTH + 1) begin
                            errors++;
                            $display("FAIL calc_cycles: got %0d required %0d", calc_n, LENGTH + 1);
                        end
                    end
                    prev_calc = (dut.state == 2'd2);
                    prev_acc  = dut.acc_p2;
                    prev_prod = dut.prod_p1;
                end
                checks++;
                if (!seen_done) begin
                    errors++;
                    $display("FAIL rotation_timeout: DONE not reached in %0d cycles", cyc);
                end
            end
        join
        checks++;
        if (res !== 16'sd184) begin
            errors++;
            $display("FAIL rotation_result: got %h required %h", res, 16'sd184);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit got;
        bit quiet;
        FIR_input   = 16'sh2000;
        input_valid = 1'b1;
        n = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            if (output_valid) got = 1'b1;
        end
        checks++;
        if (!got || n - 1 !== LENGTH + 3) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d required %0d", n - 1, LENGTH + 3);
        end
        checks++;
        if (FIR_output !== 16'sd506) begin
            errors++;
            $display("FAIL b2b_first: got %h required %h", FIR_output, 16'sd506);
        end
        @(posedge clk); #1;
        input_valid = 1'b0;
        n = 0; got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk); #1;
            n++;
            if (output_valid) got = 1'b1;
        end
        checks++;
        if (!got || n !== LENGTH + 3) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d required %0d", n, LENGTH + 3);
        end
        checks++;
        if (FIR_output !== 16'sd822) begin
            errors++;
            $display("FAIL b2b_second: got %h required %h", FIR_output, 16'sd822);
        end
        quiet = 1'b1;
        for (int i = 0; i < LENGTH + 8; i++) begin
            @(posedge clk); #1;
            if (output_valid || FIR_output !== 16'sd822) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL b2b_hold: extra pulse or output changed, out=%h required %h",
                     FIR_output, 16'sd822);
        end
    endtask

    task automatic test_mid_reset();
        logic signed [WIDTH-1:0] res;
        int lat;
        bit quiet;
        FIR_input   = 16'sh5555;
        input_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        input_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (dut.state !== 2'd2) begin
            errors++;
            $display("FAIL mid_state: got %0d required 2", dut.state);
        end
        quiet = 1'b1;
        #2;
        reset       = 1'b1;
        input_valid = 1'b1;
        #1;
        checks++;
        if (FIR_output !== 16'h0000 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL mid_async_clear: out=%h state=%0d required 0000/0", FIR_output, dut.state);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (output_valid) quiet = 1'b0;
        end
        input_valid = 1'b0;
        reset       = 1'b0;
        for (int i = 0; i < LENGTH + 8; i++) begin
            @(posedge clk); #1;
            if (output_valid) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_no_pulse: output_valid seen, required none");
        end
        send_sample(16'sh4000, res, lat);
        checks++;
        if (res !== 16'sd650) begin
            errors++;
            $display("FAIL mid_clean_start: got %h required %h", res, 16'sd650);
        end
        checks++;
        if (lat !== LENGTH + 3) begin
            errors++;
            $display("FAIL mid_clean_latency: got %0d required %0d", lat, LENGTH + 3);
        end
    endtask

    task automatic test_negative();
        logic signed [WIDTH-1:0] res;
        int lat;
        send_sample(16'sh8000, res, lat);
        checks++;
        if (res !== 16'hFD6A) begin
            errors++;
            $display("FAIL negative_exact: got %h required FD6A", res);
        end
        send_sample(16'shFFFF, res, lat);
        checks++;
        if (res !== 16'hFD75) begin
            errors++;
            $display("FAIL negative_floor: got %h required FD75", res);
        end
    endtask

    task automatic test_overflow();
        logic signed [WIDTH-1:0] res;
        logic signed [WIDTH-1:0] exp;
        int lat;
`ifdef FIR_SATURATE_EN
        exp = 16'sh7FFF;
`else
        exp = 16'sh87FE;
`endif
        for (int k = 0; k < LENGTH + 1; k++) begin
            send_sample(16'sh7FFF, res, lat);
            if (k >= LENGTH - 1) begin
                checks++;
                if (res !== exp) begin
                    errors++;
                    $display("FAIL overflow[%0d]: got %h required %h", k, res, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_zero();
        test_rotation();
        test_back_to_back();
        test_mid_reset();
        test_negative();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
